// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locked sharing of the Tx FIFO write port among NUM_REQ byte requesters (define ARB_SRC_TAG_EN to prefix each burst with a source tag byte)
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = 2
) (
  input  logic                 glb_clk,
  input  logic                 glb_rst,
  input  logic                 Cfg_ctrl_Tx_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 FIFO_ctrl_full,
  output logic                 UART_ctrl_FIFO_w_en,
  output logic [7:0]           UART_Tx_data_payload,
  output logic [ID_W-1:0]      grant_id,
  output logic                 arb_busy
);
  typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;
`ifdef ARB_SRC_TAG_EN
  localparam state_t GRANT_ST = HDR;
`else
  localparam state_t GRANT_ST = XFER;
`endif
  state_t state, nxt;
  logic [ID_W-1:0] last_grant, pick, idx;
  logic [7:0] beat_cnt;
  logic found, go, rdy, xfer, fire, hdr_wr, done;
  assign xfer = state == XFER;
  assign rdy = Cfg_ctrl_Tx_en & ~FIFO_ctrl_full & ~glb_rst;
  assign go = Cfg_ctrl_Tx_en & |req_valid;
  assign fire = xfer & rdy & req_valid[grant_id];
  assign hdr_wr = (state == HDR) & rdy;
  assign done = fire & (req_last[grant_id] | (beat_cnt + 8'd1 == 8'(MAX_BURST)));
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_ff @(posedge glb_clk)
    if (glb_rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE && go) nxt = GRANT_ST;
    if (hdr_wr) nxt = XFER;
    if (done) nxt = IDLE;
  end
  always_comb begin
    req_ready = (xfer && rdy) ? NUM_REQ'(1) << grant_id : '0;
    UART_ctrl_FIFO_w_en = fire | hdr_wr;
    UART_Tx_data_payload = xfer ? req_data[{grant_id, 3'b000} +: 8] : (state == HDR) ? {4'hA, 4'(grant_id)} : 8'h00;
    arb_busy = state != IDLE;
  end
  always_ff @(posedge glb_clk)
    if (glb_rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      if (state == IDLE && go) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (fire) beat_cnt <= beat_cnt + 8'd1;
      if (done) last_grant <= grant_id;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic glb_clk = 1'b0;
  logic glb_rst, Cfg_ctrl_Tx_en, FIFO_ctrl_full;
  logic [3:0] req_valid, req_last, req_ready, take;
  logic [31:0] req_data;
  logic UART_ctrl_FIFO_w_en, arb_busy;
  logic [7:0] UART_Tx_data_payload;
  logic [1:0] grant_id;
  logic [8:0] q [4][$];
  logic [7:0] wd [$];
  int wc [$];
  int cyc = 0;
  int vec = 0;
  int errs = 0;
  always #5 glb_clk = ~glb_clk;
  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(8), .ID_W(2)) dut (
    .glb_clk(glb_clk), .glb_rst(glb_rst), .Cfg_ctrl_Tx_en(Cfg_ctrl_Tx_en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .FIFO_ctrl_full(FIFO_ctrl_full), .UART_ctrl_FIFO_w_en(UART_ctrl_FIFO_w_en),
    .UART_Tx_data_payload(UART_Tx_data_payload), .grant_id(grant_id), .arb_busy(arb_busy)
  );
  function automatic void refresh();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = q[i].size() != 0;
      {req_last[i], req_data[8*i +: 8]} = (q[i].size() != 0) ? q[i][0] : 9'h0;
    end
  endfunction
  always @(negedge glb_clk) begin
    cyc++;
    take = req_valid & req_ready;
    if (UART_ctrl_FIFO_w_en) begin
      wd.push_back(UART_Tx_data_payload);
      wc.push_back(cyc);
    end
  end
  always @(posedge glb_clk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (take[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  end
  task automatic nxt(input int n = 1);
    repeat (n) begin
      @(negedge glb_clk);
      #1;
    end
  endtask
  task automatic do_reset();
    glb_rst = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    refresh();
    nxt(2);
    glb_rst = 1'b0;
    wd.delete();
    wc.delete();
  endtask
  task automatic test_reset();
    glb_rst = 1'b1;
    nxt(2);
    vec++;
    if ({arb_busy, UART_ctrl_FIFO_w_en, req_ready, UART_Tx_data_payload, grant_id} !== 16'h0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b wen=%b rdy=%b data=%h gid=%0d want all 0", arb_busy, UART_ctrl_FIFO_w_en, req_ready, UART_Tx_data_payload, grant_id);
    end
    glb_rst = 1'b0;
    wd.delete();
    wc.delete();
  endtask
  task automatic test_single();
    int n0 = cyc;
    logic [7:0] e [3] = '{8'h11, 8'h22, 8'h33};
    q[0].push_back({1'b0, 8'h11});
    q[0].push_back({1'b0, 8'h22});
    q[0].push_back({1'b1, 8'h33});
    refresh();
    nxt(1);
    vec++;
    if (grant_id !== 2'd0 || arb_busy !== 1'b1) begin
      errs++;
      $display("FAIL single_grant: got gid=%0d busy=%b want gid=0 busy=1", grant_id, arb_busy);
    end
    nxt(3);
    vec++;
    if (arb_busy !== 1'b0) begin
      errs++;
      $display("FAIL single_release: got busy=%b want 0", arb_busy);
    end
    vec++;
    if (wd.size() != 3) begin
      errs++;
      $display("FAIL single_count: got %0d writes want 3", wd.size());
    end
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (k >= wd.size() || wd[k] !== e[k] || wc[k] != n0 + 1 + k) begin
        errs++;
        $display("FAIL single_byte%0d: got %h@%0d want %h@%0d", k, wd[k], wc[k], e[k], n0 + 1 + k);
      end
    end
  endtask
  task automatic test_round_robin();
    int n0;
    do_reset();
    n0 = cyc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) q[i].push_back({1'b1, 8'(i * 16 + k)});
    refresh();
    nxt(17);
    vec++;
    if (wd.size() != 8) begin
      errs++;
      $display("FAIL rr_count: got %0d writes want 8", wd.size());
    end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (k >= wd.size() || wd[k] !== 8'((k % 4) * 16 + k / 4) || wc[k] != n0 + 1 + 2 * k) begin
        errs++;
        $display("FAIL rr_write%0d: got %h@%0d want %h@%0d", k, wd[k], wc[k], 8'((k % 4) * 16 + k / 4), n0 + 1 + 2 * k);
      end
    end
  endtask
  task automatic test_max_burst();
    int n0;
    logic [7:0] ed [$];
    int ec [$];
    do_reset();
    n0 = cyc;
    for (int k = 0; k < 20; k++) q[2].push_back({1'b0, 8'(8'h40 + k)});
    for (int k = 0; k < 3; k++) q[3].push_back({k == 2, 8'(8'h90 + k)});
    refresh();
    for (int k = 0; k < 8; k++) begin ed.push_back(8'(8'h40 + k)); ec.push_back(n0 + 1 + k); end
    for (int k = 0; k < 3; k++) begin ed.push_back(8'(8'h90 + k)); ec.push_back(n0 + 10 + k); end
    for (int k = 0; k < 8; k++) begin ed.push_back(8'(8'h48 + k)); ec.push_back(n0 + 14 + k); end
    for (int k = 0; k < 4; k++) begin ed.push_back(8'(8'h50 + k)); ec.push_back(n0 + 23 + k); end
    nxt(28);
    vec++;
    if (wd.size() != 23) begin
      errs++;
      $display("FAIL burst_count: got %0d writes want 23", wd.size());
    end
    for (int k = 0; k < 23; k++) begin
      vec++;
      if (k >= wd.size() || wd[k] !== ed[k] || wc[k] != ec[k]) begin
        errs++;
        $display("FAIL burst_write%0d: got %h@%0d want %h@%0d", k, wd[k], wc[k], ed[k], ec[k]);
      end
    end
    q[1].push_back({1'b1, 8'hEE});
    refresh();
    nxt(3);
    vec++;
    if (arb_busy !== 1'b1 || grant_id !== 2'd2 || wd.size() != 23) begin
      errs++;
      $display("FAIL burst_hold: got busy=%b gid=%0d writes=%0d want busy=1 gid=2 writes=23", arb_busy, grant_id, wd.size());
    end
  endtask
  task automatic test_fifo_full();
    int n0;
    do_reset();
    n0 = cyc;
    for (int k = 0; k < 6; k++) q[1].push_back({k == 5, 8'(8'h60 + k)});
    refresh();
    nxt(2);
    FIFO_ctrl_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      nxt(1);
      vec++;
      if (UART_ctrl_FIFO_w_en !== 1'b0 || req_ready !== 4'h0 || arb_busy !== 1'b1) begin
        errs++;
        $display("FAIL full_stall%0d: got wen=%b rdy=%b busy=%b want 0 0000 1", s, UART_ctrl_FIFO_w_en, req_ready, arb_busy);
      end
    end
    FIFO_ctrl_full = 1'b0;
    nxt(5);
    vec++;
    if (wd.size() != 6 || arb_busy !== 1'b0) begin
      errs++;
      $display("FAIL full_count: got %0d writes busy=%b want 6 busy=0", wd.size(), arb_busy);
    end
    for (int k = 0; k < 6; k++) begin
      vec++;
      if (k >= wd.size() || wd[k] !== 8'(8'h60 + k) || wc[k] != n0 + ((k < 2) ? 1 : 6) + k) begin
        errs++;
        $display("FAIL full_write%0d: got %h@%0d want %h@%0d", k, wd[k], wc[k], 8'(8'h60 + k), n0 + ((k < 2) ? 1 : 6) + k);
      end
    end
  endtask
  task automatic test_enable_and_reset();
    int n0;
    do_reset();
    n0 = cyc;
    for (int k = 0; k < 5; k++) q[3].push_back({k == 4, 8'(8'h70 + k)});
    refresh();
    nxt(2);
    Cfg_ctrl_Tx_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      nxt(1);
      vec++;
      if (UART_ctrl_FIFO_w_en !== 1'b0 || grant_id !== 2'd3 || arb_busy !== 1'b1) begin
        errs++;
        $display("FAIL en_pause%0d: got wen=%b gid=%0d busy=%b want 0 3 1", s, UART_ctrl_FIFO_w_en, grant_id, arb_busy);
      end
    end
    Cfg_ctrl_Tx_en = 1'b1;
    nxt(4);
    vec++;
    if (wd.size() != 5 || grant_id !== 2'd3) begin
      errs++;
      $display("FAIL en_count: got %0d writes gid=%0d want 5 gid=3", wd.size(), grant_id);
    end
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (k >= wd.size() || wd[k] !== 8'(8'h70 + k) || wc[k] != n0 + ((k < 2) ? 1 : 5) + k) begin
        errs++;
        $display("FAIL en_write%0d: got %h@%0d want %h@%0d", k, wd[k], wc[k], 8'(8'h70 + k), n0 + ((k < 2) ? 1 : 5) + k);
      end
    end
    Cfg_ctrl_Tx_en = 1'b0;
    q[0].push_back({1'b1, 8'hD0});
    refresh();
    nxt(3);
    vec++;
    if (arb_busy !== 1'b0 || wd.size() != 5) begin
      errs++;
      $display("FAIL en_no_grant: got busy=%b writes=%0d want busy=0 writes=5", arb_busy, wd.size());
    end
    Cfg_ctrl_Tx_en = 1'b1;
    nxt(3);
    vec++;
    if (wd.size() != 6 || wd[5] !== 8'hD0) begin
      errs++;
      $display("FAIL en_regrant: got writes=%0d last=%h want 6 D0", wd.size(), wd[wd.size() - 1]);
    end
    wd.delete();
    wc.delete();
    n0 = cyc;
    for (int k = 0; k < 6; k++) q[1].push_back({k == 5, 8'(8'h80 + k)});
    refresh();
    nxt(2);
    glb_rst = 1'b1;
    #1;
    vec++;
    if (UART_ctrl_FIFO_w_en !== 1'b0 || req_ready !== 4'h0) begin
      errs++;
      $display("FAIL rst_gate: got wen=%b rdy=%b want 0 0000", UART_ctrl_FIFO_w_en, req_ready);
    end
    for (int i = 0; i < 4; i++) q[i].delete();
    refresh();
    nxt(1);
    vec++;
    if ({arb_busy, UART_ctrl_FIFO_w_en, req_ready, UART_Tx_data_payload, grant_id} !== 16'h0) begin
      errs++;
      $display("FAIL rst_mid_outputs: got busy=%b wen=%b rdy=%b data=%h gid=%0d want all 0", arb_busy, UART_ctrl_FIFO_w_en, req_ready, UART_Tx_data_payload, grant_id);
    end
    glb_rst = 1'b0;
    q[1].push_back({1'b1, 8'hB0});
    q[0].push_back({1'b1, 8'hA0});
    refresh();
    nxt(1);
    vec++;
    if (grant_id !== 2'd0) begin
      errs++;
      $display("FAIL rst_first_winner: got gid=%0d want 0", grant_id);
    end
    nxt(3);
    vec++;
    if (wd.size() != 4 || wd[0] !== 8'h80 || wd[1] !== 8'h81 || wd[2] !== 8'hA0 || wd[3] !== 8'hB0 || wc[2] != n0 + 4 || wc[3] != n0 + 6) begin
      errs++;
      $display("FAIL rst_stream: got n=%0d %h %h %h %h want 4 80 81 A0 B0", wd.size(), wd[0], wd[1], wd[2], wd[3]);
    end
  endtask
  task automatic test_tag();
    int n0;
`ifdef ARB_SRC_TAG_EN
    logic [7:0] e [3] = '{8'hA1, 8'hC0, 8'hC1};
    int n = 3;
`else
    logic [7:0] e [3] = '{8'hC0, 8'hC1, 8'h00};
    int n = 2;
`endif
    do_reset();
    n0 = cyc;
    q[1].push_back({1'b0, 8'hC0});
    q[1].push_back({1'b1, 8'hC1});
    refresh();
    nxt(5);
    vec++;
    if (wd.size() != n || grant_id !== 2'd1 || arb_busy !== 1'b0) begin
      errs++;
      $display("FAIL tag_count: got writes=%0d gid=%0d busy=%b want %0d 1 0", wd.size(), grant_id, arb_busy, n);
    end
    for (int k = 0; k < n; k++) begin
      vec++;
      if (k >= wd.size() || wd[k] !== e[k] || wc[k] != n0 + 1 + k) begin
        errs++;
        $display("FAIL tag_byte%0d: got %h@%0d want %h@%0d", k, wd[k], wc[k], e[k], n0 + 1 + k);
      end
    end
  endtask
  initial begin
    glb_rst = 1'b1;
    Cfg_ctrl_Tx_en = 1'b1;
    FIFO_ctrl_full = 1'b0;
    take = 4'h0;
    refresh();
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_fifo_full();
    test_enable_and_reset();
    test_tag();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the UART transmit FIFO write port among NUM_REQ independent byte-stream requesters. It sits between the requesters and the Tx FIFO that feeds the UART transmitter.
- Grants are burst-locked: a winner keeps the FIFO until its last byte or until MAX_BURST bytes have been written.
- Arbitration is gated by the Tx enable configuration bit.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_BURST, 8, max bytes per grant before forced release (1..255)
ID_W, 2, width of grant_id; must equal clog2(NUM_REQ)

Ports:
glb_clk  input  1  single clock; all logic rising-edge
glb_rst  input  1  reset, synchronous, active-high
Cfg_ctrl_Tx_en  input  1  transmit enable; 0 blocks new grants and all writes
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  input  NUM_REQ  per-requester last-byte-of-message flag, qualified by valid
req_ready  output  NUM_REQ  per-requester accept; a byte transfers when valid & ready
FIFO_ctrl_full  input  1  Tx FIFO full
UART_ctrl_FIFO_w_en  output  1  Tx FIFO write strobe
UART_Tx_data_payload  output  8  Tx FIFO write data
grant_id  output  ID_W  index of current or most recent grantee
arb_busy  output  1  1 while a grant is held (state != IDLE)

Behaviour:
- Clock and reset: one clock, glb_clk. Reset glb_rst is synchronous and active-high.
- Reset state: state=IDLE; last_grant=NUM_REQ-1, so requester 0 has top priority first; beat_cnt=0; grant_id=0; arb_busy=0; req_ready=0; UART_ctrl_FIFO_w_en=0; UART_Tx_data_payload=0.
- Reset mid-burst: the burst is abandoned, with no further writes from the cycle reset is sampled.
- FSM states: IDLE, XFER (plus HDR under the optional feature).
- IDLE: when Cfg_ctrl_Tx_en=1 and any req_valid=1, pick the first valid index searching last_grant+1, +2, ... modulo NUM_REQ.
  - Register the pick into grant_id; clear beat_cnt; go to XFER.
  - Grant latency is 1 cycle from valid seen in IDLE to ready possible.
  - No writes occur in IDLE.
- XFER, for granted index g:
  - req_ready[g] = Cfg_ctrl_Tx_en & ~FIFO_ctrl_full. This is combinational from registered state, so the FIFO is never written when full.
  - All other req_ready bits are 0.
  - UART_ctrl_FIFO_w_en = req_valid[g] & req_ready[g]. This is combinational: the write happens in the same cycle as the handshake.
  - UART_Tx_data_payload = req_data[g] while in XFER, 0 otherwise.
  - Each transfer increments beat_cnt (8-bit).
- Release: on a transfer with req_last[g]=1, or with beat_cnt+1 == MAX_BURST, set last_grant=g and go to IDLE.
  - This gives a fixed 1-cycle bubble between bursts.
  - The next grant goes to a different requester whenever another is valid.
- Boundary cases:
  - Grantee drops valid mid-burst: the grant is held with no timeout; other requesters wait.
  - Cfg_ctrl_Tx_en falls mid-burst: ready and writes stop; the grant is held and the burst resumes when enable returns. No new grant is issued while enable=0.
  - FIFO_ctrl_full: stalls the current beat only; the FSM stays in its state.
  - Single requester: after release it is re-granted after the 1-cycle bubble.
  - req_last together with the MAX_BURST limit on the same beat: a single release.
- Output changes: grant_id changes only on the IDLE->grant transition; between bursts it holds the previous grantee.

Optional Feature:
Macro: ARB_SRC_TAG_EN
- Defined: the grant goes IDLE->HDR. HDR writes one tag byte {4'hA, 4-bit zero-extended grant_id} when Cfg_ctrl_Tx_en & ~FIFO_ctrl_full, then goes to XFER.
  - req_ready is 0 in HDR.
  - The tag does not count toward MAX_BURST.
  - A stall in HDR holds the state.
- Not defined: no HDR state; IDLE goes directly to XFER; the byte stream carries payload only.

Test Plan:
- Reset, then req_valid=4'b0001 sending 3 bytes 0x11,0x22,0x33 (last on 0x33) with the FIFO never full -> grant_id=0; exactly 3 writes in 3 consecutive cycles starting 1 cycle after valid; arb_busy falls after the 3rd write.
- All 4 requesters valid continuously with 1-byte messages -> grant order 0,1,2,3,0,1; one write every 2 cycles.
- Requester 2 streams 20 bytes with no last and MAX_BURST=8 while requester 3 is valid -> 8 bytes from 2, then 3 is granted, then 2 resumes for the next 8 bytes.
- FIFO_ctrl_full held high for 5 cycles in mid-burst -> w_en=0 and req_ready=0 for those 5 cycles; no byte lost or duplicated; the burst completes afterwards.
- Cfg_ctrl_Tx_en dropped for 4 cycles mid-burst, then glb_rst pulsed during a later burst -> writes pause then resume with grant_id unchanged; after reset all outputs are 0 and requester 0 wins the next arbitration.
- With ARB_SRC_TAG_EN, requester 1 sends 2 bytes -> FIFO sees 0xA1, byte0, byte1; without the macro it sees only byte0, byte1.
